// File: rtl/delay_measure.sv
// Purpose : measure the i_clk-cycle latency between a rising edge on i_start and the matching rising edge on i_echo.
// Latency : the result is registered on the clock edge that samples the echo rise, or the timeout count.
// Backpres: the result is held in DONE with o_valid high until o_valid && i_ready. Edges seen while DONE are dropped.
//
// Ports:
//   i_clk, i_rst_n     : clock (rising edge) and asynchronous active-low reset
//   i_start, i_echo    : stimulus and echo lines; only their 0->1 transitions matter
//   o_delay_cnt        : measured latency, or P_TIMEOUT when no echo arrived
//   o_timeout          : 1 when o_delay_cnt reports an abandoned measurement
//   o_valid / i_ready  : result handshake
//   o_busy             : high while a measurement is counting
module delay_measure #(
  parameter int P_CNT_WIDTH = 16,
  parameter int P_TIMEOUT   = 1000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_echo,
  input  logic                   i_ready,
  output logic [P_CNT_WIDTH-1:0] o_delay_cnt,
  output logic                   o_timeout,
  output logic                   o_valid,
  output logic                   o_busy
);

  localparam logic [P_CNT_WIDTH-1:0] LP_TIMEOUT = P_CNT_WIDTH'(P_TIMEOUT);
  localparam logic [P_CNT_WIDTH-1:0] LP_ONE     = P_CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 state_q;
  logic [P_CNT_WIDTH-1:0] cnt_q;
  logic [P_CNT_WIDTH-1:0] cnt_d;
  logic [P_CNT_WIDTH-1:0] delay_q;
  logic                   timeout_q;
  logic                   valid_q;
  logic                   busy_q;
  logic                   prev_start_q;
  logic                   prev_echo_q;
  logic                   rise_start;
  logic                   rise_echo;

  assign rise_start = i_start && !prev_start_q;
  assign rise_echo  = i_echo  && !prev_echo_q;
  assign cnt_d      = cnt_q + LP_ONE;

  assign o_delay_cnt = delay_q;
  assign o_timeout   = timeout_q;
  assign o_valid     = valid_q;
  assign o_busy      = busy_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      delay_q      <= '0;
      timeout_q    <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      // Reset high so a line already asserted at reset release is not an edge.
      prev_start_q <= 1'b1;
      prev_echo_q  <= 1'b1;
    end else begin
      prev_start_q <= i_start;
      prev_echo_q  <= i_echo;
      case (state_q)
        S_IDLE: begin
          if (rise_start && rise_echo) begin
            delay_q   <= '0;
            timeout_q <= 1'b0;
            valid_q   <= 1'b1;
            state_q   <= S_DONE;
          end else if (rise_start) begin
            // The start-edge sample counts as the first elapsed edge.
            cnt_q   <= LP_ONE;
            busy_q  <= 1'b1;
            state_q <= S_COUNT;
          end
        end
        S_COUNT: begin
          // Echo is checked first so an echo landing on the timeout count wins.
          if (rise_echo) begin
            delay_q   <= cnt_q;
            timeout_q <= 1'b0;
            valid_q   <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_DONE;
          end else if (cnt_q == LP_TIMEOUT) begin
            delay_q   <= LP_TIMEOUT;
            timeout_q <= 1'b1;
            valid_q   <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
